// File: rtl/rv32_core.sv
// Single-cycle RV32I integer core: one instruction per clock, external combinational
// instruction/data memories, data memory written on the same edge that commits the registers.
module rv32_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_data_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] instr_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_alu_a, w_alu_b, w_alu_res;
    logic [2:0]  w_alu_f3;
    logic        w_alu_alt;
    logic        w_legal, w_writes, w_br_take, w_rd_we;
    logic [31:0] w_rd_val, w_next_pc;

    assign w_opcode = instr_data_i[6:0];
    assign w_rd     = instr_data_i[11:7];
    assign w_f3     = instr_data_i[14:12];
    assign w_rs1    = instr_data_i[19:15];
    assign w_rs2    = instr_data_i[24:20];
    assign w_f7     = instr_data_i[31:25];

    assign w_imm_i = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
    assign w_imm_s = {{20{instr_data_i[31]}}, instr_data_i[31:25], instr_data_i[11:7]};
    assign w_imm_b = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                      instr_data_i[30:25], instr_data_i[11:8], 1'b0};
    assign w_imm_u = {instr_data_i[31:12], 12'h000};
    assign w_imm_j = {{11{instr_data_i[31]}}, instr_data_i[31], instr_data_i[19:12],
                      instr_data_i[20], instr_data_i[30:21], 1'b0};

    // Reads see the pre-edge value, so a same-cycle write to the read register returns old data.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    always_comb begin
        w_legal   = 1'b0;
        w_alu_a   = w_rs1_val;
        w_alu_b   = w_imm_i;
        w_alu_f3  = 3'b000;
        w_alu_alt = 1'b0;
        case (w_opcode)
            OP_LUI:    begin w_legal = 1'b1; w_alu_a = 32'd0; w_alu_b = w_imm_u; end
            OP_AUIPC:  begin w_legal = 1'b1; w_alu_a = r_pc;  w_alu_b = w_imm_u; end
            OP_JAL:    begin w_legal = 1'b1; w_alu_a = r_pc;  w_alu_b = w_imm_j; end
            OP_JALR:   w_legal = (w_f3 == 3'b000);
            OP_BRANCH: begin
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_alu_b = w_rs2_val;
            end
            OP_LOAD:   w_legal = (w_f3 == 3'b010);
            OP_STORE:  begin w_legal = (w_f3 == 3'b010); w_alu_b = w_imm_s; end
            OP_IMM: begin
                w_alu_f3  = w_f3;
                w_alu_alt = (w_f3 == 3'b101) && instr_data_i[30];
                if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'h00);
                else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                else                     w_legal = 1'b1;
            end
            OP_REG: begin
                w_alu_b   = w_rs2_val;
                w_alu_f3  = w_f3;
                w_alu_alt = instr_data_i[30];
                w_legal   = (w_f7 == 7'h00) ||
                            ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_res = 32'd0;
        case (w_alu_f3)
            3'b000: w_alu_res = w_alu_alt ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);
            3'b001: w_alu_res = w_alu_a << w_alu_b[4:0];
            3'b010: w_alu_res = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            3'b011: w_alu_res = {31'd0, w_alu_a < w_alu_b};
            3'b100: w_alu_res = w_alu_a ^ w_alu_b;
            3'b101: w_alu_res = w_alu_alt ? 32'($signed(w_alu_a) >>> w_alu_b[4:0])
                                          : (w_alu_a >> w_alu_b[4:0]);
            3'b110: w_alu_res = w_alu_a | w_alu_b;
            default: w_alu_res = w_alu_a & w_alu_b;
        endcase
    end

    always_comb begin
        w_br_take = 1'b0;
        case (w_f3)
            3'b000: w_br_take = (w_rs1_val == w_rs2_val);
            3'b001: w_br_take = (w_rs1_val != w_rs2_val);
            3'b100: w_br_take = $signed(w_rs1_val) <  $signed(w_rs2_val);
            3'b101: w_br_take = $signed(w_rs1_val) >= $signed(w_rs2_val);
            3'b110: w_br_take = (w_rs1_val <  w_rs2_val);
            3'b111: w_br_take = (w_rs1_val >= w_rs2_val);
            default: w_br_take = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_val  = w_alu_res;
        w_next_pc = r_pc + 32'd4;
        w_writes  = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: w_writes = 1'b1;
            OP_JAL: begin
                w_writes  = 1'b1;
                w_rd_val  = r_pc + 32'd4;
                w_next_pc = w_alu_res;
            end
            OP_JALR: begin
                w_writes  = 1'b1;
                w_rd_val  = r_pc + 32'd4;
                w_next_pc = w_alu_res & 32'hFFFF_FFFE;
            end
            OP_BRANCH: if (w_br_take) w_next_pc = r_pc + w_imm_b;
            OP_LOAD: begin
                w_writes = 1'b1;
                w_rd_val = mem_data_i;
            end
            default: w_writes = 1'b0;
        endcase
        // Illegal encodings degrade to a NOP.
        if (!w_legal) begin
            w_next_pc = r_pc + 32'd4;
            w_writes  = 1'b0;
        end
    end

    assign w_rd_we      = rst_i && w_writes && (w_rd != 5'd0);
    assign mem_we_o     = rst_i && w_legal && (w_opcode == OP_STORE);
    assign mem_addr_o   = w_alu_res;
    assign mem_data_o   = w_rs2_val;
    assign instr_addr_o = r_pc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (w_rd_we) r_regs[w_rd] <= w_rd_val;
        end
    end
endmodule

// File: tb/tb_rv32_core.sv
// Bench for rv32_core: directed programs plus random programs run in lockstep with an
// instruction-level model of RV32I; the core is observed through its PC and memory ports.
module tb_rv32_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_data, mem_rdata, iaddr, mem_addr, mem_wdata;
    logic        mem_we;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    logic [31:0] m_dmem [0:63];
    logic [31:0] m_x [0:31];
    logic [31:0] m_pc;
    logic [31:0] prog [$];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    assign instr_data = imem[iaddr[7:2]];
    assign mem_rdata  = dmem[mem_addr[7:2]];

    rv32_core #(.RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .instr_data_i(instr_data), .mem_data_i(mem_rdata),
        .instr_addr_o(iaddr), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] alu(logic [2:0] f3, logic alt, logic [31:0] x, logic [31:0] y);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Architectural step of one instruction against the model state.
    task automatic m_step(input logic [31:0] i, output logic we, output logic ld,
                          output logic [31:0] addr, output logic [31:0] data);
        logic [31:0] a, b, ii, is, ib, iu, ij, npc, wv;
        logic [2:0] f3;
        logic [6:0] f7;
        logic wen, take;
        a = m_x[i[19:15]]; b = m_x[i[24:20]]; f3 = i[14:12]; f7 = i[31:25];
        ii = {{20{i[31]}}, i[31:20]};
        is = {{20{i[31]}}, i[31:25], i[11:7]};
        ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        iu = {i[31:12], 12'h0};
        ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        we = 0; ld = 0; addr = 0; data = b; npc = m_pc + 4; wen = 0; wv = 0; take = 0;
        case (i[6:0])
            7'h37: begin wen = 1; wv = iu; end
            7'h17: begin wen = 1; wv = m_pc + iu; end
            7'h6f: begin wen = 1; wv = m_pc + 4; npc = m_pc + ij; end
            7'h67: if (f3 == 0) begin wen = 1; wv = m_pc + 4; npc = (a + ii) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = $signed(a) < $signed(b);
                    3'd5: take = $signed(a) >= $signed(b);
                    3'd6: take = a < b;
                    3'd7: take = a >= b;
                    default: take = 0;
                endcase
                if (take) npc = m_pc + ib;
            end
            7'h03: if (f3 == 2) begin ld = 1; addr = a + ii; wen = 1; wv = m_dmem[addr[7:2]]; end
            7'h23: if (f3 == 2) begin we = 1; addr = a + is; m_dmem[addr[7:2]] = b; end
            7'h13: if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20)) ||
                       (f3 != 1 && f3 != 5)) begin
                wen = 1; wv = alu(f3, f3 == 5 && i[30], a, ii);
            end
            7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                wen = 1; wv = alu(f3, i[30], a, b);
            end
            default: ;
        endcase
        m_pc = npc;
        if (wen && i[11:7] != 0) m_x[i[11:7]] = wv;
    endtask

    // mode 0: run, 1: hold reset, 2: run with occasional reset pulses
    task automatic run(input int n, input int mode);
        logic r, e_we, e_ld, c_we;
        logic [31:0] e_a, e_d, c_a, c_d;
        for (int c = 0; c < n; c++) begin
            r = !((mode == 1) || (mode == 2 && $urandom_range(0, 99) < 3));
            rst = r;
            @(negedge clk);
            chk("pc", iaddr, m_pc);
            if (!r) begin
                chk("we_in_reset", {31'd0, mem_we}, 32'd0);
                m_pc = 32'h0;
                for (int k = 0; k < 32; k++) m_x[k] = 32'd0;
            end else begin
                m_step(imem[m_pc[7:2]], e_we, e_ld, e_a, e_d);
                chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
                if (e_we) begin
                    chk("st_addr", mem_addr, e_a);
                    chk("st_data", mem_wdata, e_d);
                end
                if (e_ld) chk("ld_addr", mem_addr, e_a);
            end
            c_we = mem_we; c_a = mem_addr; c_d = mem_wdata;
            @(posedge clk); #1;
            if (c_we) dmem[c_a[7:2]] = c_d;
        end
    endtask

    task automatic start();
        for (int k = 0; k < 64; k++) imem[k] = (k < prog.size()) ? prog[k] : 32'h0;
        run(2, 1);
    endtask

    task automatic set_mem(input int idx, input logic [31:0] v);
        dmem[idx] = v; m_dmem[idx] = v;
    endtask

    function automatic logic [31:0] rnd_instr();
        int k = $urandom_range(0, 99);
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [4:0] r1 = 5'($urandom_range(0, 7));
        logic [4:0] r2 = 5'($urandom_range(0, 7));
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic [31:0] imm = $urandom;
        logic [31:0] off = 32'((int'($urandom_range(0, 24)) - 12) * 4);
        logic [6:0] f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if (k < 15) begin
            if (f3 == 1 || f3 == 5) imm = {20'd0, f7, imm[4:0]};
            return enc_i(imm, r1, f3, rd, 7'h13);
        end
        if (k < 30) return enc_r(f7, r2, r1, f3, rd);
        if (k < 40) return enc_i(imm, r1, 3'd2, rd, 7'h03);
        if (k < 56) return enc_s(imm, r2, r1, 3'd2);
        if (k < 66) return enc_b(off, r2, r1, f3);
        if (k < 70) return enc_j(off, rd);
        if (k < 74) return enc_i(32'($urandom_range(0, 255)), r1, 3'd0, rd, 7'h67);
        if (k < 80) return {imm[31:12], rd, 7'h37};
        if (k < 84) return {imm[31:12], rd, 7'h17};
        if (k < 90) return enc_s(imm, r2, r1, f3 | 3'd4);
        if (k < 95) return $urandom;
        return 32'h0;
    endfunction

    initial begin
        for (int k = 0; k < 64; k++) begin imem[k] = 0; set_mem(k, 0); end
        for (int k = 0; k < 32; k++) m_x[k] = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        m_pc = 0;
        chk("reset_pc", iaddr, 32'h0);

        // load/ALU/store chain
        prog = '{enc_i(64, 0, 2, 1, 7'h03), enc_i(123, 1, 0, 2, 7'h13), enc_i(51, 2, 0, 3, 7'h13),
                 enc_i(63, 3, 7, 3, 7'h13), enc_s(64, 3, 0, 2), enc_i(0, 0, 0, 0, 7'h13)};
        start();
        set_mem(16, 3);
        run(4, 0);
        chk("t1_sw_we", {31'd0, mem_we}, 32'd1);
        chk("t1_sw_addr", mem_addr, 32'd64);
        chk("t1_sw_data", mem_wdata, 32'h31);
        run(2, 0);
        chk("t1_pc", iaddr, 32'h18);
        chk("t1_mem", dmem[16], 32'h31);

        // reset in the middle of the program, then rerun
        run(2, 1);
        chk("t2_pc0", iaddr, 32'h0);
        set_mem(16, 3);
        run(3, 0);
        run(2, 1);
        chk("t2_pc_mid", iaddr, 32'h0);
        chk("t2_we_mid", {31'd0, mem_we}, 32'd0);
        run(6, 0);
        chk("t2_pc", iaddr, 32'h18);
        chk("t2_mem", dmem[16], 32'h31);

        // x0 is hard-wired
        prog = '{enc_i(5, 0, 0, 0, 7'h13), enc_r(0, 0, 0, 0, 4), enc_s(0, 4, 0, 2), enc_s(4, 0, 0, 2)};
        set_mem(0, 32'hDEAD_BEEF); set_mem(1, 32'h1234_5678);
        start();
        run(4, 0);
        chk("t3_x4", dmem[0], 32'h0);
        chk("t3_x0", dmem[1], 32'h0);

        // branches
        prog = '{enc_i(32'hFFF, 0, 0, 5, 7'h13), enc_b(8, 0, 5, 3'd1), enc_s(0, 5, 0, 2),
                 enc_b(8, 0, 5, 3'd0), enc_b(8, 5, 0, 3'd6), 32'h0, 32'h0, 32'h0};
        start();
        run(2, 0);
        chk("t4_bne", iaddr, 32'd12);
        run(1, 0);
        chk("t4_beq", iaddr, 32'd16);
        run(1, 0);
        chk("t4_bltu", iaddr, 32'd24);

        // jal / jalr
        prog = '{32'h13, 32'h13, enc_j(16, 1), enc_s(0, 1, 0, 2), 32'h0, 32'h0,
                 enc_i(3, 1, 0, 0, 7'h67)};
        set_mem(0, 32'hFFFF_FFFF);
        start();
        run(3, 0);
        chk("t5_jal", iaddr, 32'd24);
        run(1, 0);
        chk("t5_jalr", iaddr, 32'd14);
        run(1, 0);
        chk("t5_link", dmem[0], 32'd12);

        // shifts and an all-zero word
        prog = '{{20'h80000, 5'd6, 7'h37}, enc_i(32'h404, 6, 5, 7, 7'h13),
                 enc_i(32'h004, 6, 5, 8, 7'h13), enc_s(0, 7, 0, 2), enc_s(4, 8, 0, 2), 32'h0};
        start();
        run(6, 0);
        chk("t6_srai", dmem[0], 32'hF800_0000);
        chk("t6_srli", dmem[1], 32'h0800_0000);
        chk("t6_nop_pc", iaddr, 32'd24);

        // random programs with occasional resets
        for (int p = 0; p < 20; p++) begin
            prog.delete();
            for (int k = 0; k < 64; k++) prog.push_back(rnd_instr());
            for (int k = 0; k < 64; k++) set_mem(k, $urandom);
            start();
            run(300, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
